act_rep_encoder: RTL and testbench

Producer-side encoder for the activation stream consumed by MUL_BATCH. It accepts groups of GROUP_SIZE activations and computes the GROUP_SIZE×GROUP_SIZE repetition matrix. It then emits the packed word (values plus rep_info) on the act_data_in / act_valid_in / act_avail_out interface, so duplicate activations are multiplied once. It sits between the activation reader and MUL_BATCH, and keeps a running count of multiplications saved.

---
 rtl/act_rep_encoder_pkg.sv | 32 +++
 rtl/act_rep_encoder_rep_matrix_gen.sv | 55 +++++
 rtl/act_rep_encoder.sv | 118 +++++++++++
 tb/tb_act_rep_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/act_rep_encoder_pkg.sv
// -----------------------------------------------------------------------------
// act_rep_encoder_pkg
// Shared definitions for the activation repetition encoder and its consumer
// (MUL_BATCH). Both sides use these so that they agree on the rep_info bit
// ordering and on the packed data_out layout.
//   - DEF_* : default geometry of the activation stream
//   - rep_bit_idx()  : bit of rep_info meaning "value c is served by rep r"
//   - values_lsb() / rep_info_lsb() : field offsets inside data_out
// -----------------------------------------------------------------------------
package act_rep_encoder_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_GROUP_SIZE    = 4;
    localparam int DEF_LOG_MAX_SAVED = 32;

    // rep_info is a row-major GROUP_SIZE x GROUP_SIZE matrix: row = representative,
    // column = served value.
    function automatic int rep_bit_idx(input int r, input int c, input int group_size);
        return r * group_size + c;
    endfunction

    // Values occupy the low bits of data_out.
    function automatic int values_lsb();
        return 0;
    endfunction

    // rep_info sits directly above the packed values.
    function automatic int rep_info_lsb(input int group_size, input int data_width);
        return group_size * data_width;
    endfunction

endpackage

// File: rtl/act_rep_encoder_rep_matrix_gen.sv
// -----------------------------------------------------------------------------
// rep_matrix_gen
// Purely combinational repetition-matrix generator for one activation group.
//   values     in  GROUP_SIZE*DATA_WIDTH  value k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rep_enable in  1                      0 = identity matrix
//   rep_info   out GROUP_SIZE*GROUP_SIZE  bit r*GROUP_SIZE+c: value c served by r
//   rep_count  out CNT_W                  number of representatives in the group
// -----------------------------------------------------------------------------
module rep_matrix_gen
    import act_rep_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GROUP_SIZE = DEF_GROUP_SIZE,
    parameter int REP_INFO   = GROUP_SIZE * GROUP_SIZE,
    parameter int CNT_W      = $clog2(GROUP_SIZE + 1)
) (
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] values,
    input  logic                             rep_enable,
    output logic [REP_INFO-1:0]              rep_info,
    output logic [CNT_W-1:0]                 rep_count
);

    // First-occurrence mask: index holds a value not seen at any lower index.
    logic [GROUP_SIZE-1:0] is_rep;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the loops can leave a signal unassigned (no latch).
        rep_info  = '0;
        is_rep    = '0;
        rep_count = '0;
        for (int c = 0; c < GROUP_SIZE; c++) begin
            logic found;
            logic eq;
            found = 1'b0;
            // Scan upward from index 0: the first matching index is the
            // representative. r == c always matches, so every column gets
            // exactly one bit.
            for (int r = 0; r <= c; r++) begin
                if (rep_enable)
                    eq = (values[r*DATA_WIDTH +: DATA_WIDTH] == values[c*DATA_WIDTH +: DATA_WIDTH]);
                else
                    eq = (r == c);
                if (!found && eq) begin
                    rep_info[rep_bit_idx(r, c, GROUP_SIZE)] = 1'b1;
                    found = 1'b1;
                end
            end
            is_rep[c] = rep_info[rep_bit_idx(c, c, GROUP_SIZE)];
        end
        for (int k = 0; k < GROUP_SIZE; k++)
            rep_count = rep_count + CNT_W'(is_rep[k]);
    end

endmodule

// File: rtl/act_rep_encoder.sv
// -----------------------------------------------------------------------------
// act_rep_encoder
// Producer-side encoder for the MUL_BATCH activation stream. Two-stage
// pipeline: S1 holds raw values, S2 holds values + rep_info + rep count.
// Keeps a running count of multiplications saved by repetition sharing.
//   clk         in  clock, rising edge
//   rst         in  synchronous active-low reset
//   configure   in  clears saved_count when the pipeline is empty
//   rep_enable  in  1 = detect repetitions, 0 = identity matrix
//   data_in     in  GROUP_SIZE activations
//   valid_in    in  data_in valid
//   avail_out   out can accept a group this cycle
//   data_out    out {rep_info, values}
//   valid_out   out data_out valid
//   avail_in    in  downstream can accept
//   saved_count out non-representatives emitted since last clear
// -----------------------------------------------------------------------------
module act_rep_encoder
    import act_rep_encoder_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int GROUP_SIZE    = DEF_GROUP_SIZE,
    parameter int REP_INFO      = GROUP_SIZE * GROUP_SIZE,
    parameter int LOG_MAX_SAVED = DEF_LOG_MAX_SAVED
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  configure,
    input  logic                                  rep_enable,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]      data_in,
    input  logic                                  valid_in,
    output logic                                  avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH+REP_INFO-1:0] data_out,
    output logic                                  valid_out,
    input  logic                                  avail_in,
    output logic [LOG_MAX_SAVED-1:0]              saved_count
);

    localparam int VAL_W   = GROUP_SIZE * DATA_WIDTH;
    localparam int CNT_W   = $clog2(GROUP_SIZE + 1);
    localparam int VAL_LSB = values_lsb();
    localparam int REP_LSB = rep_info_lsb(GROUP_SIZE, DATA_WIDTH);

    logic                 s1_valid;
    logic [VAL_W-1:0]     s1_data;
    logic                 s2_valid;
    logic [VAL_W-1:0]     s2_data;
    logic [REP_INFO-1:0]  s2_rep_info;
    logic [CNT_W-1:0]     s2_rep_count;

    logic [REP_INFO-1:0]  s1_rep_info;
    logic [CNT_W-1:0]     s1_rep_count;

    logic adv1, adv2, configure_clear, in_xfer, out_xfer;

    rep_matrix_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .GROUP_SIZE (GROUP_SIZE),
        .REP_INFO   (REP_INFO),
        .CNT_W      (CNT_W)
    ) u_rep_matrix_gen (
        .values     (s1_data),
        .rep_enable (rep_enable),
        .rep_info   (s1_rep_info),
        .rep_count  (s1_rep_count)
    );

    assign adv2            = !s2_valid || avail_in;
    assign adv1            = !s1_valid || adv2;
    assign configure_clear = configure && !s1_valid && !s2_valid;
    // rst gating keeps avail_out low while reset is held.
    assign avail_out       = adv1 && !configure_clear && rst;
    assign in_xfer         = valid_in && avail_out;
    assign out_xfer        = s2_valid && avail_in;

    assign valid_out                        = s2_valid;
    assign data_out[VAL_LSB +: VAL_W]       = s2_data;
    assign data_out[REP_LSB +: REP_INFO]    = s2_rep_info;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: data registers are reset too (not just valids) because
            // data_out has a defined reset value; the state is tiny.
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s2_valid     <= 1'b0;
            s2_data      <= '0;
            s2_rep_info  <= '0;
            s2_rep_count <= '0;
            saved_count  <= '0;
        end else begin
            // NOTE: all state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (adv1) begin
                s1_valid <= in_xfer;
                if (in_xfer)
                    s1_data <= data_in;
            end
            // S2 only loads a real group; when empty it keeps its last
            // contents so data_out stays stable while stalled.
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data      <= s1_data;
                    s2_rep_info  <= s1_rep_info;
                    s2_rep_count <= s1_rep_count;
                end
            end
            // configure_clear needs S2 empty, so it never collides with out_xfer.
            if (configure_clear)
                saved_count <= '0;
            else if (out_xfer)
                saved_count <= saved_count + LOG_MAX_SAVED'(GROUP_SIZE)
                                           - LOG_MAX_SAVED'(s2_rep_count);
        end
    end

endmodule

// File: tb/tb_act_rep_encoder.sv
// -----------------------------------------------------------------------------
// tb_act_rep_encoder
// Directed self-checking bench for act_rep_encoder with hand-computed
// expected rep_info matrices and saved counts.
// -----------------------------------------------------------------------------
module tb_act_rep_encoder;

    localparam int DW  = 8;
    localparam int GS  = 4;
    localparam int RI  = GS * GS;
    localparam int LMS = 32;
    localparam int OW  = GS * DW + RI;

    logic              clk = 1'b0;
    logic              rst;
    logic              configure;
    logic              rep_enable;
    logic [GS*DW-1:0]  data_in;
    logic              valid_in;
    logic              avail_out;
    logic [OW-1:0]     data_out;
    logic              valid_out;
    logic              avail_in;
    logic [LMS-1:0]    saved_count;

    int tests_run = 0;
    int tests_failed = 0;
    logic [LMS-1:0] exp_saved;

    act_rep_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .configure   (configure),
        .rep_enable  (rep_enable),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .avail_out   (avail_out),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .avail_in    (avail_in),
        .saved_count (saved_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [GS*DW-1:0] grp(input logic [7:0] v0, input logic [7:0] v1,
                                              input logic [7:0] v2, input logic [7:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    // Stall-test groups with hand-derived rep_info and saved counts.
    logic [GS*DW-1:0] sg [4];
    logic [RI-1:0]    sr [4];

    initial begin
        int in_idx, out_idx;
        logic acc, outx;

        rst = 1'b0; configure = 1'b0; rep_enable = 1'b1;
        data_in = '0; valid_in = 1'b0; avail_in = 1'b1;
        exp_saved = '0;

        // ---------------- reset ----------------
        step(); step();
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_avail_out", 64'(avail_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_saved", 64'(saved_count), 64'd0);
        rst = 1'b1;
        #1;
        check("post_rst_avail_out", 64'(avail_out), 64'd1);

        // ---------------- all equal ----------------
        data_in = grp(5, 5, 5, 5); valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("eq_lat1_valid", 64'(valid_out), 64'd0);
        step();
        check("eq_valid", 64'(valid_out), 64'd1);
        check("eq_data", 64'(data_out), 64'({16'h000F, grp(5, 5, 5, 5)}));
        check("eq_saved_before", 64'(saved_count), 64'd0);
        step();
        exp_saved = 3;
        check("eq_saved", 64'(saved_count), 64'(exp_saved));
        check("eq_drained", 64'(valid_out), 64'd0);

        // ---------------- back-to-back ----------------
        data_in = grp(1, 2, 1, 3); valid_in = 1'b1;
        step();
        data_in = grp(2, 3, 2, 4);
        step();
        valid_in = 1'b0;
        check("b2b_a", 64'(data_out), 64'({16'h8025, grp(1, 2, 1, 3)}));
        check("b2b_a_valid", 64'(valid_out), 64'd1);
        step();
        check("b2b_b", 64'(data_out), 64'({16'h8025, grp(2, 3, 2, 4)}));
        check("b2b_b_valid", 64'(valid_out), 64'd1);
        step();
        exp_saved = exp_saved + 2;
        check("b2b_saved", 64'(saved_count), 64'(exp_saved));

        // ---------------- rep_enable = 0 ----------------
        rep_enable = 1'b0;
        data_in = grp(1, 2, 3, 4); valid_in = 1'b1;
        step();
        data_in = grp(7, 7, 7, 7);
        step();
        valid_in = 1'b0;
        check("id_a", 64'(data_out), 64'({16'h8421, grp(1, 2, 3, 4)}));
        step();
        check("id_b", 64'(data_out), 64'({16'h8421, grp(7, 7, 7, 7)}));
        step();
        check("id_saved", 64'(saved_count), 64'(exp_saved));
        rep_enable = 1'b1;

        // ---------------- stall with 4 groups ----------------
        sg[0] = grp(9, 9, 1, 2); sr[0] = 16'h8403;  // saves 1
        sg[1] = grp(3, 4, 5, 6); sr[1] = 16'h8421;  // saves 0
        sg[2] = grp(0, 0, 0, 0); sr[2] = 16'h000F;  // saves 3
        sg[3] = grp(1, 2, 2, 1); sr[3] = 16'h0069;  // saves 2
        in_idx = 0; out_idx = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            avail_in = (cyc >= 5);
            valid_in = (in_idx < 4);
            data_in  = (in_idx < 4) ? sg[in_idx] : '0;
            #1;
            if (cyc < 5) begin
                check($sformatf("stall_avail_out_%0d", cyc), 64'(avail_out), (cyc < 2) ? 64'd1 : 64'd0);
                if (cyc >= 2)
                    check($sformatf("stall_hold_%0d", cyc), 64'(data_out), 64'({sr[0], sg[0]}));
            end
            acc  = valid_in && avail_out;
            outx = valid_out && avail_in;
            if (outx) begin
                if (out_idx < 4)
                    check($sformatf("stall_out_%0d", out_idx), 64'(data_out), 64'({sr[out_idx], sg[out_idx]}));
                else
                    check("stall_extra_out", 64'(out_idx), 64'd3);
                out_idx++;
            end
            step();
            if (acc) in_idx++;
        end
        valid_in = 1'b0;
        check("stall_in_count", 64'(in_idx), 64'd4);
        check("stall_out_count", 64'(out_idx), 64'd4);
        exp_saved = exp_saved + 6;
        check("stall_saved", 64'(saved_count), 64'(exp_saved));

        // ---------------- reset mid-flight ----------------
        avail_in = 1'b0;
        data_in = grp(1, 1, 1, 1); valid_in = 1'b1;
        step();
        data_in = grp(2, 2, 2, 2);
        step();
        valid_in = 1'b0;
        rst = 1'b0;
        step();
        check("mid_rst_valid", 64'(valid_out), 64'd0);
        check("mid_rst_saved", 64'(saved_count), 64'd0);
        check("mid_rst_avail", 64'(avail_out), 64'd0);
        exp_saved = '0;
        rst = 1'b1; avail_in = 1'b1;
        #1;
        check("mid_rst_release_avail", 64'(avail_out), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mid_rst_no_stale_%0d", k), 64'(valid_out), 64'd0);
        end

        // ---------------- configure ----------------
        data_in = grp(0, 0, 0, 0); valid_in = 1'b1;
        step(); step();
        valid_in = 1'b0;
        step(); step(); step();
        exp_saved = 6;
        check("cfg_pre_saved", 64'(saved_count), 64'(exp_saved));
        // Busy pipeline: configure ignored.
        data_in = grp(5, 5, 5, 5); valid_in = 1'b1;
        step();
        valid_in = 1'b0; configure = 1'b1;
        #1;
        check("cfg_busy_avail", 64'(avail_out), 64'd1);
        step();
        configure = 1'b0;
        step();
        exp_saved = exp_saved + 3;
        check("cfg_busy_saved", 64'(saved_count), 64'(exp_saved));
        // Empty pipeline: clear.
        configure = 1'b1;
        #1;
        check("cfg_empty_avail", 64'(avail_out), 64'd0);
        step();
        configure = 1'b0;
        check("cfg_cleared", 64'(saved_count), 64'd0);
        #1;
        check("cfg_avail_back", 64'(avail_out), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
